// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-3 master: FSM state encoding, frame
// length, bit-order constants and the transmit shift helper.
package spi_pkg;

    localparam int unsigned SPI_NBITS = 8;
    // Bit counter must hold 0..SPI_NBITS inclusive.
    localparam int unsigned SPI_CNT_W = 4;

    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        LOW  = 3'd2,
        HIGH = 3'd3,
        GAP  = 3'd4
    } spi_state_e;

    // Advance the transmit register by one bit, back-filling with ones so the
    // line rests high once the payload has been shifted out.
    function automatic logic [SPI_NBITS-1:0] spi_tx_shift(
        input logic [SPI_NBITS-1:0] v,
        input logic                 mlb
    );
        if (mlb == MSB_FIRST) begin
            return {v[SPI_NBITS-2:0], 1'b1};
        end
        return {1'b1, v[SPI_NBITS-1:1]};
    endfunction

endpackage

// File: rtl/spi_sck_div.sv
// Half-period tick generator for the SPI master.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   en   - run enable; while low the counter is held at its reload value
//   tick - high for one clk cycle every CLK_DIV cycles while enabled
module spi_sck_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Down-counter: reload on tick or while disabled, so the first tick after
    // enabling lands exactly CLK_DIV cycles later.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-3 (CPOL=1, CPHA=1) master performing one full-duplex 8-bit
// transfer per start request, with selectable bit order.
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   start           - transfer request, honoured only while idle
//   tdata, mlb      - byte to send and bit order (1 = MSB first), captured on accept
//   sdin            - MISO
//   ss, sck, sdout  - slave select (active low), serial clock, MOSI
//   busy            - transfer in progress, including the trailing ss-high gap
//   done            - one-cycle completion pulse
//   rdata           - last received byte, updated with done
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tdata,
    input  logic       mlb,
    input  logic       sdin,
    output logic       ss,
    output logic       sck,
    output logic       sdout,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata
);

    spi_state_e             state_q, state_d;
    logic [SPI_NBITS-1:0]   treg_q, treg_d;
    logic [SPI_NBITS-1:0]   rreg_q, rreg_d;
    logic [SPI_NBITS-1:0]   rdata_q, rdata_d;
    logic [SPI_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   mlb_q, mlb_d;
    logic                   ss_q, ss_d;
    logic                   sck_q, sck_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick;

    spi_sck_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // Next-state and output logic; every state advances only on a tick.
    always_comb begin
        state_d = state_q;
        treg_d  = treg_q;
        rreg_d  = rreg_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        mlb_d   = mlb_q;
        ss_d    = ss_q;
        sck_d   = sck_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    treg_d  = tdata;
                    mlb_d   = mlb;
                    cnt_d   = '0;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                // First falling edge: bit 0 is already on sdout, no shift.
                if (tick) begin
                    sck_d   = 1'b0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tick) begin
                    sck_d = 1'b1;
                    if (mlb_q == MSB_FIRST) begin
                        rreg_d = {rreg_q[SPI_NBITS-2:0], sdin};
                    end else begin
                        rreg_d = {sdin, rreg_q[SPI_NBITS-1:1]};
                    end
                    cnt_d   = cnt_q + SPI_CNT_W'(1);
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    if (cnt_q < SPI_CNT_W'(SPI_NBITS)) begin
                        sck_d   = 1'b0;
                        treg_d  = spi_tx_shift(treg_q, mlb_q);
                        state_d = LOW;
                    end else begin
                        ss_d    = 1'b1;
                        rdata_d = rreg_q;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // Guarantees a minimum ss-high time before the next frame.
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            treg_q  <= '1;
            rreg_q  <= '1;
            rdata_q <= '0;
            cnt_q   <= '0;
            mlb_q   <= MSB_FIRST;
            ss_q    <= 1'b1;
            sck_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            treg_q  <= treg_d;
            rreg_q  <= rreg_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            mlb_q   <= mlb_d;
            ss_q    <= ss_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ss    = ss_q;
    assign sck   = sck_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    // MOSI presents the current head bit while selected, rests high otherwise.
    assign sdout = ss_q ? 1'b1 : ((mlb_q == MSB_FIRST) ? treg_q[SPI_NBITS-1] : treg_q[0]);

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: mode-3 slave model on a CLK_DIV=4
// instance and a loopback CLK_DIV=2 instance.
module tb_spi_master;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DIV2  = 2;
    localparam int unsigned T_SS  = 17 * DIV;
    localparam int unsigned BOUND = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic [7:0] tdata;
    logic       mlb;
    logic       sdin;
    logic       ss, sck, sdout, busy, done;
    logic [7:0] rdata;
    logic       sdin2;
    logic       ss2, sck2, sdout2, busy2, done2;
    logic [7:0] rdata2;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .tdata(tdata), .mlb(mlb), .sdin(sdin),
        .ss(ss), .sck(sck), .sdout(sdout), .busy(busy), .done(done), .rdata(rdata)
    );

    spi_master #(.CLK_DIV(DIV2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .tdata(tdata), .mlb(mlb), .sdin(sdin2),
        .ss(ss2), .sck(sck2), .sdout(sdout2), .busy(busy2), .done(done2), .rdata(rdata2)
    );

    assign sdin2 = sdout2;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit i of a frame on the wire for byte b in the given order.
    function automatic logic wire_bit(input logic [7:0] b, input logic m, input int i);
        return m ? b[7-i] : b[i];
    endfunction

    // ---------------- bus monitor and mode-3 slave ----------------
    logic       ss_prev = 1'b1, sck_prev = 1'b1, ss2_prev = 1'b1, sck2_prev = 1'b1;
    int         ss_low_cnt = 0, ss_high_cnt = 0, last_low = 0, last_gap = 0;
    int         frames = 0, done_cnt = 0, fall_cnt = 0, cyc = 0;
    int         rise2_last = -1, p2min = 0, p2max = 0, rises2 = 0;
    logic [7:0] sl_byte = 8'hFF;
    logic       sl_mlb = 1'b1;
    logic       sdin_drv = 1'b1;
    logic       rx_q[$];

    assign sdin = sdin_drv;

    always @(negedge clk) begin
        if (ss_prev && !ss) begin
            frames++;
            last_gap    = ss_high_cnt;
            ss_high_cnt = 0;
            ss_low_cnt  = 0;
            fall_cnt    = 0;
            rx_q.delete();
            sdin_drv    = wire_bit(sl_byte, sl_mlb, 0);
        end
        if (!ss_prev && ss) last_low = ss_low_cnt;
        if (!ss) ss_low_cnt++; else ss_high_cnt++;
        if (!ss && !sck_prev && sck) rx_q.push_back(sdout);
        if (!ss && sck_prev && !sck) begin
            fall_cnt++;
            if (fall_cnt >= 2 && fall_cnt <= 8) sdin_drv = wire_bit(sl_byte, sl_mlb, fall_cnt - 1);
        end
        if (done) done_cnt++;

        if (ss2_prev && !ss2) begin
            rise2_last = -1; p2min = 1000; p2max = 0; rises2 = 0;
        end
        if (!ss2 && !sck2_prev && sck2) begin
            if (rise2_last >= 0) begin
                if (cyc - rise2_last < p2min) p2min = cyc - rise2_last;
                if (cyc - rise2_last > p2max) p2max = cyc - rise2_last;
            end
            rise2_last = cyc;
            rises2++;
        end

        cyc++;
        ss_prev = ss; sck_prev = sck; ss2_prev = ss2; sck2_prev = sck2;
    end

    // ---------------- helpers ----------------
    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(posedge clk); #1;
            if (done) begin ok = 1; break; end
        end
        check({tag, "_done_seen"}, 32'(ok), 1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] td, input logic m, input logic [7:0] sb);
        logic [7:0] obs = '0, exp = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < rx_q.size()) obs[7-i] = rx_q[i];
            exp[7-i] = wire_bit(td, m, i);
        end
        check({tag, "_rdata"}, rdata, sb);
        check({tag, "_nbits"}, rx_q.size(), 8);
        check({tag, "_sdout_bits"}, obs, exp);
    endtask

    // One frame; poke=1 fires extra start requests mid-transfer with scrambled inputs.
    task automatic do_frame(input string tag, input logic [7:0] td, input logic m,
                            input logic [7:0] sb, input bit poke);
        int d0 = done_cnt, f0 = frames;
        sl_byte = sb; sl_mlb = m; tdata = td; mlb = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_ss_fall"}, ss, 0);
        check({tag, "_busy_rise"}, busy, 1);
        if (poke) begin
            repeat (9) @(posedge clk);
            #1 start = 1'b1; tdata = ~td; mlb = ~m;
            @(posedge clk); #1 start = 1'b0;
            repeat (9) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done(tag);
        check({tag, "_ss_rise"}, ss, 1);
        check_frame(tag, td, m, sb);
        repeat (DIV - 1) @(posedge clk);
        #1;
        check({tag, "_busy_gap"}, busy, 1);
        check({tag, "_done_1cyc"}, done, 0);
        @(posedge clk); #1;
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_ss_low_len"}, last_low, T_SS);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_one_frame"}, frames - f0, 1);
    endtask

    logic [7:0] b2b_td [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        logic [7:0] sb, td;
        logic       m;
        int         d0, f0;
        bit         ok;

        rst = 1'b1; start = 1'b0; start2 = 1'b0; tdata = 8'h00; mlb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ss", ss, 1);
        check("reset_sck", sck, 1);
        check("reset_sdout", sdout, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rdata", rdata, 8'h00);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        do_frame("msb_a5", 8'hA5, 1'b1, 8'h3C, 0);
        do_frame("lsb_01", 8'h01, 1'b0, 8'h80, 0);

        // Requests during a transfer are dropped and inputs are not re-sampled.
        f0 = frames;
        do_frame("ignore", 8'h5A, 1'b1, 8'hC7, 1);
        tdata = 8'h5A; mlb = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("ignore_no_extra_frame", frames - f0, 1);
        check("ignore_idle", busy, 0);

        // Start held high: back-to-back frames separated by the gap.
        start = 1'b1;
        f0 = frames;
        for (int k = 0; k < 3; k++) begin
            sb = 8'($urandom);
            sl_byte = sb; sl_mlb = 1'b1; tdata = b2b_td[k]; mlb = 1'b1;
            wait_done($sformatf("b2b%0d", k));
            if (k == 2) start = 1'b0;
            check_frame($sformatf("b2b%0d", k), b2b_td[k], 1'b1, sb);
            if (k > 0) check($sformatf("b2b%0d_gap_ok", k), 32'(last_gap >= int'(DIV)), 1);
        end
        repeat (3 * DIV) @(posedge clk);
        #1;
        check("b2b_frames", frames - f0, 3);
        check("b2b_idle", busy, 0);

        // Reset mid-frame after the 4th sck rise; prior frame leaves rdata = 0.
        do_frame("pre_rst", 8'($urandom), 1'($urandom), 8'h00, 0);
        sl_byte = 8'hFF; sl_mlb = 1'b1; tdata = 8'($urandom); mlb = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(posedge clk); #1;
            if (rx_q.size() >= 4) begin ok = 1; break; end
        end
        check("rst_reach_rise4", 32'(ok), 1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 1);
        check("rst_sdout", sdout, 1);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (DIV * 20) @(posedge clk);
        #1;
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_ss_idle", ss, 1);
        do_frame("post_rst", 8'h96, 1'b0, 8'h5B, 0);

        for (int k = 0; k < 5; k++) begin
            td = 8'($urandom); m = 1'($urandom); sb = 8'($urandom);
            do_frame($sformatf("rand%0d", k), td, m, sb, 0);
        end

        // CLK_DIV=2 loopback.
        for (int k = 0; k < 2; k++) begin
            tdata = (k == 0) ? 8'hC3 : 8'($urandom);
            mlb = (k == 0) ? 1'b1 : 1'b0;
            td = tdata;
            start2 = 1'b1;
            @(posedge clk); #1 start2 = 1'b0;
            ok = 0;
            for (int i = 0; i < BOUND; i++) begin
                @(posedge clk); #1;
                if (done2) begin ok = 1; break; end
            end
            check($sformatf("lb%0d_done_seen", k), 32'(ok), 1);
            check($sformatf("lb%0d_rdata", k), rdata2, td);
            check($sformatf("lb%0d_rises", k), rises2, 8);
            check($sformatf("lb%0d_sck_pmin", k), p2min, 2 * DIV2);
            check($sformatf("lb%0d_sck_pmax", k), p2max, 2 * DIV2);
            repeat (2 * DIV2) @(posedge clk);
            #1;
            check($sformatf("lb%0d_idle", k), busy2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-channel SPI mode-3 master. CPOL=1: sck idles high. CPHA=1: data changes on the sck falling edge and is sampled on the rising edge.
- Performs one full-duplex 8-bit transfer per start request: shifts tdata out on sdout and captures sdin into rdata.
- Bit order is selectable MSB- or LSB-first.
- Sits on the system clock and drives the ss/sck/sdout pins of the existing mode-3 slave peripherals.

Parameters:
- CLK_DIV, 4, sck half-period in clk cycles; legal range >= 2. sck frequency = f_clk / (2*CLK_DIV).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  transfer request; sampled only while busy=0.
- tdata  input  8  byte to transmit; captured in the cycle start is accepted.
- mlb  input  1  bit order; 1 = MSB first, 0 = LSB first; captured with tdata.
- sdin  input  1  serial data from the slave (MISO).
- ss  output  1  slave select, active low, registered.
- sck  output  1  serial clock, registered; idles high.
- sdout  output  1  serial data to the slave (MOSI); idles high.
- busy  output  1  high from the cycle after start is accepted until the inter-frame gap ends.
- done  output  1  one-cycle pulse when the transfer completes.
- rdata  output  8  received byte; updated only when done pulses, held otherwise.

Behaviour:
- Reset values (asynchronous, take effect immediately): ss=1, sck=1, sdout=1, busy=0, done=0, rdata=8'h00, internal shift registers=8'hFF, bit count=0, state=IDLE.
- Half-period timer: counts CLK_DIV-1 down to 0. A tick is emitted at 0, then the timer reloads. It runs only outside IDLE.
- IDLE:
  - When start=1, latch tdata into treg and mlb into mlb_q, clear the bit count, set ss=0 and busy=1, go to LEAD.
  - When start=0, hold all outputs.
- LEAD (sck=1, ss=0): lasts one half-period. On the tick, set sck=0 (falling edge #1) and go to LOW.
- sdout: combinationally equals treg[7] when mlb_q=1, treg[0] when mlb_q=0, whenever ss=0; equals 1 when ss=1.
- The first bit is valid from ss assertion. Each falling edge after #1 shifts treg:
  - MSB first: shift left, fill with 1.
  - LSB first: shift right, fill with 1.
- LOW (sck=0): on the tick, set sck=1 (rising edge) and sample sdin in that same clk cycle:
  - MSB first: rreg = {rreg[6:0], sdin}.
  - LSB first: rreg = {sdin, rreg[7:1]}.
  - Increment the bit count, then go to HIGH.
- HIGH (sck=1):
  - If bit count < 8: on the tick, set sck=0, shift treg, go to LOW.
  - If bit count = 8: on the tick (trailing half-period), set ss=1, rdata=rreg, done=1, clear the bit count, go to GAP.
- GAP (ss=1, sck=1): lasts one half-period, guaranteeing a minimum ss-high time. On the tick, set busy=0 and go to IDLE.
- Timing:
  - ss is low for exactly 17*CLK_DIV cycles.
  - Start accepted at edge N: ss falls at N+1; done and ss rise at N+1+17*CLK_DIV; busy falls CLK_DIV cycles later.
- start while busy=1 is ignored; no queuing.
- start held high continuously produces back-to-back frames, each separated by the GAP.
- tdata/mlb changes during a transfer have no effect.
- Reset asserted mid-transfer aborts immediately to the reset values; rdata is not updated and no done pulse is produced.
- done and a new start acceptance never coincide, because of GAP.

Decomposition:
- Package spi_pkg: state encoding (IDLE, LEAD, LOW, HIGH, GAP), constant SPI_NBITS=8, bit-order constants MSB_FIRST=1 and LSB_FIRST=0.
- One sub-module, spi_sck_div: the half-period tick counter, parameterised by CLK_DIV, with inputs clk, rst, en and output tick.

Test Plan:
- CLK_DIV=4, mlb=1, tdata=8'hA5, bench mode-3 slave returning 8'h3C -> sdout bits sampled at sck rises are 1,0,1,0,0,1,0,1; rdata=8'h3C; done pulses once; ss low for 68 cycles.
- mlb=0, tdata=8'h01, slave returns 8'h80 -> first sdout bit 1, then seven 0s; rdata=8'h80.
- start pulsed at cycles 10 and 20 of a transfer -> second request ignored; exactly one frame on the bus; one done pulse.
- start held high for three frames, tdata=8'h11/22/33 -> three frames, each separated by ss high for >= 4 cycles; rdata matches each slave byte in order.
- rst asserted after the 4th sck rise -> ss=1, sck=1, sdout=1, busy=0 immediately; rdata remains the previous value; no done pulse; next frame completes normally.
- CLK_DIV=2 loopback (sdin tied to sdout), tdata=8'hC3 -> rdata=8'hC3; sck period = 4 clk cycles.
